// File: rtl/ps2_key_rx.sv
// ps2_key_rx: receive-only PS/2 keyboard front end in the pixel clock domain.
// Synchronizes and de-glitches the raw PS/2 pins, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), folds E0/F0 prefixes into a
// single scancode event and keeps held-key levels for Space and Enter.
//
// Handshake: scan_valid and frame_err are one-cycle strobes with no ready
// input. scan_code/scan_ext/scan_break are valid in the scan_valid cycle and
// hold until the next event, so a consumer may also sample them later.
module ps2_key_rx #(
  parameter int CLK_HZ     = 25_200_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk_pixel,
  input  logic       resetn,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_break,
  output logic       frame_err,
  output logic       key_space,
  output logic       key_enter,
  output logic [1:0] dbg_state
);

  // Timeout length in pixel clocks; computed in 64 bits so fractional MHz
  // clocks (25.2 MHz) do not lose precision.
  localparam longint TO_CYC_L  = (longint'(CLK_HZ) * longint'(TIMEOUT_US)) / longint'(1_000_000);
  localparam int     TO_CYC    = int'(TO_CYC_L);
  localparam int     TO_W      = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_VAL = TO_W'(TO_CYC);
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic       clk_meta, clk_sync;
  logic       dat_meta, dat_sync;
  logic [7:0] filt_cnt;
  logic       clk_filt;
  logic       clk_filt_q;
  logic       sample;

  // Two-flop synchronizers; reset to 1 because an idle PS/2 bus floats high.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_i;
      clk_sync <= clk_meta;
      dat_meta <= ps2_dat_i;
      dat_sync <= dat_meta;
    end
  end

  // Clock filter: the filtered clock follows only after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      filt_cnt <= 8'd0;
      clk_filt <= 1'b1;
    end else if (clk_sync == clk_filt) begin
      filt_cnt <= 8'd0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_sync;
      filt_cnt <= 8'd0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      clk_filt_q <= 1'b1;
    end else begin
      clk_filt_q <= clk_filt;
    end
  end

  // One-cycle sample event on each filtered falling edge; dat_sync is the bit.
  assign sample = clk_filt_q & ~clk_filt;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t          state, state_n;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_ok;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            byte_ok;
  logic            err_now;

  // A frame stalls only outside IDLE; an edge in the same cycle takes priority.
  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_VAL);

  // State register.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic: sample events advance the frame, timeouts abandon it.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (sample && !dat_sync) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (sample) begin
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end else if (timeout_hit) begin
          state_n = ST_IDLE;
        end
      end
      ST_PARITY: begin
        if (sample) state_n = ST_STOP;
        else if (timeout_hit) state_n = ST_IDLE;
      end
      ST_STOP: begin
        if (sample || timeout_hit) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output decode: good byte on a clean stop bit, error on bad stop/parity or timeout.
  always_comb begin
    byte_ok = 1'b0;
    err_now = 1'b0;
    if (state == ST_STOP && sample) begin
      byte_ok = dat_sync && parity_ok;
      err_now = !(dat_sync && parity_ok);
    end else if (timeout_hit && !sample) begin
      err_now = 1'b1;
    end
  end

  // Frame datapath: bit counter, LSB-first shifter, parity result, gap timer.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      parity_ok <= 1'b0;
      to_cnt    <= '0;
    end else begin
      if (state == ST_IDLE || sample) begin
        to_cnt <= '0;
      end else if (!timeout_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (sample) begin
        unique case (state)
          ST_IDLE: bit_cnt <= 3'd0;
          ST_DATA: begin
            shift_reg <= {dat_sync, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          // Odd parity over data plus parity bit means XOR of all nine is 1.
          ST_PARITY: parity_ok <= ^{dat_sync, shift_reg};
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Byte strobe / error strobe registers
  // ---------------------------------------------------------------------
  logic       byte_stb;
  logic [7:0] byte_q;

  // Register the completed byte and the error pulse for the protocol layer.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      byte_stb  <= 1'b0;
      byte_q    <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= byte_ok;
      frame_err <= err_now;
      if (byte_ok) byte_q <= shift_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Protocol layer and key state
  // ---------------------------------------------------------------------
  logic ext_flag, brk_flag;

  // Fold E0/F0 prefixes into one event; an error discards pending prefixes.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      scan_valid <= 1'b0;
      scan_code  <= 8'd0;
      scan_ext   <= 1'b0;
      scan_break <= 1'b0;
      key_space  <= 1'b0;
      key_enter  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_stb) begin
        if (byte_q == CODE_EXT) begin
          ext_flag <= 1'b1;
        end else if (byte_q == CODE_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          scan_valid <= 1'b1;
          scan_code  <= byte_q;
          scan_ext   <= ext_flag;
          scan_break <= brk_flag;
          ext_flag   <= 1'b0;
          brk_flag   <= 1'b0;
          // Key levels change in the same cycle the event is published.
          if (byte_q == CODE_SPACE && !ext_flag) key_space <= ~brk_flag;
          if (byte_q == CODE_ENTER) key_enter <= ~brk_flag;
        end
      end
    end
  end

endmodule
